// File: rtl/f32_stream_argmax.sv
// f32_stream_argmax
// Streaming argmax/argmin over frames of IEEE-754 binary32 words.
// Each accepted beat is compared against the running winner. Subnormals count
// as zero of their sign, +0 equals -0, and NaNs never win. The beat flagged
// with in_last closes the frame. One cycle later the result is presented and
// held until the consumer accepts it.
//
// Ports
//   clk        single rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   high while accumulating (a beat is taken on in_valid & in_ready)
//   in_data    binary32 element
//   in_last    final beat of the frame
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes the result on out_valid & out_ready
//   out_value  original bits of the winner, or 32'h7FC0_0000 if all were NaN
//   out_index  in-frame index of the winner (0 if all were NaN)
//   out_nan    at least one NaN was seen in the frame
//   out_ovf    frame was longer than 2^IDX_W beats, so the index wrapped
module f32_stream_argmax #(
    parameter int IDX_W    = 8,
    parameter bit FIND_MIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_value,
    output logic [IDX_W-1:0] out_index,
    output logic             out_nan,
    output logic             out_ovf
);

    localparam logic [0:0]  ACCUM    = 1'b0;
    localparam logic [0:0]  HOLD     = 1'b1;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Subnormals collapse to a zero magnitude. Otherwise {exp, frac} already
    // orders magnitudes correctly as an unsigned number.
    function automatic logic [30:0] magnitude(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 31'd0 : x[30:0];
    endfunction

    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic [30:0] ma;
        logic [30:0] mb;
        logic        res;
        ma = magnitude(a);
        mb = magnitude(b);
        if (is_nan(a) || is_nan(b))
            res = 1'b0;
        else if ((ma == 31'd0) && (mb == 31'd0))
            res = 1'b0;                 // +0, -0 and subnormals all tie
        else if (a[31] != b[31])
            res = !a[31];               // the positive operand wins
        else if (!a[31])
            res = (ma > mb);
        else
            res = (ma < mb);            // both negative: smaller magnitude is larger
        return res;
    endfunction

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] cnt_reg;
    logic [31:0]      best_value_reg;
    logic [IDX_W-1:0] best_index_reg;
    logic             have_best_reg;
    logic             nan_reg;
    logic             ovf_reg;

    logic             accept;
    logic             beat_nan;
    logic             better;
    logic             take;
    logic [31:0]      win_value;
    logic [IDX_W-1:0] win_index;
    logic             win_have;
    logic             frame_nan;
    logic             frame_ovf;

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);

    always_comb begin
        accept    = in_valid && (state_reg == ACCUM);
        beat_nan  = is_nan(in_data);
        better    = FIND_MIN ? gt(best_value_reg, in_data) : gt(in_data, best_value_reg);
        take      = accept && !beat_nan && (!have_best_reg || better);
        win_value = take ? in_data : best_value_reg;
        win_index = take ? cnt_reg : best_index_reg;
        win_have  = have_best_reg || take;
        frame_nan = nan_reg || (accept && beat_nan);
        // Overflow means a further beat will reuse an index. A frame of
        // exactly 2^IDX_W beats ends on the top index and does not overflow.
        frame_ovf = ovf_reg || (accept && !in_last && (cnt_reg == IDX_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ACCUM;
            cnt_reg        <= '0;
            best_value_reg <= '0;
            best_index_reg <= '0;
            have_best_reg  <= 1'b0;
            nan_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            out_value      <= '0;
            out_index      <= '0;
            out_nan        <= 1'b0;
            out_ovf        <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            state_reg <= HOLD;
                            out_value <= win_have ? win_value : QNAN;
                            out_index <= win_have ? win_index : '0;
                            out_nan   <= frame_nan;
                            out_ovf   <= frame_ovf;
                        end else begin
                            cnt_reg        <= cnt_reg + IDX_ONE;
                            best_value_reg <= win_value;
                            best_index_reg <= win_index;
                            have_best_reg  <= win_have;
                            nan_reg        <= frame_nan;
                            ovf_reg        <= frame_ovf;
                        end
                    end
                end
                default: begin
                    // The accumulator is cleared as the result is accepted.
                    // Incoming beats are ignored until then.
                    if (out_ready) begin
                        state_reg      <= ACCUM;
                        cnt_reg        <= '0;
                        best_value_reg <= '0;
                        best_index_reg <= '0;
                        have_best_reg  <= 1'b0;
                        nan_reg        <= 1'b0;
                        ovf_reg        <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f32_stream_argmax.sv
// tb_f32_stream_argmax
// Drives three instances in lockstep from shared inputs:
//   - argmax with an 8-bit index
//   - argmin with an 8-bit index
//   - argmax with a 2-bit index
// Fixed frames come from a table of hand-derived results. Random frames are
// checked against a real-valued reference model.
module tb_f32_stream_argmax;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        a_ready, a_valid, a_nan, a_ovf;
    logic [31:0] a_value;
    logic [7:0]  a_index;
    logic        b_ready, b_valid, b_nan, b_ovf;
    logic [31:0] b_value;
    logic [7:0]  b_index;
    logic        c_ready, c_valid, c_nan, c_ovf;
    logic [31:0] c_value;
    logic [1:0]  c_index;

    always #5 clk = ~clk;

    f32_stream_argmax #(.IDX_W(8), .FIND_MIN(1'b0)) u_max (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_valid),
        .out_ready(out_ready), .out_value(a_value), .out_index(a_index),
        .out_nan(a_nan), .out_ovf(a_ovf));

    f32_stream_argmax #(.IDX_W(8), .FIND_MIN(1'b1)) u_min (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_valid),
        .out_ready(out_ready), .out_value(b_value), .out_index(b_index),
        .out_nan(b_nan), .out_ovf(b_ovf));

    f32_stream_argmax #(.IDX_W(2), .FIND_MIN(1'b0)) u_nar (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(c_valid),
        .out_ready(out_ready), .out_value(c_value), .out_index(c_index),
        .out_nan(c_nan), .out_ovf(c_ovf));

    typedef struct {
        logic [31:0] w [6];
        int          len;
        logic [31:0] max_val;
        int          max_idx;
        logic [31:0] min_val;
        int          min_idx;
        logic        nan;
        int          n_idx;   // index seen by the 2-bit instance
        logic        n_ovf;
    } vec_t;

    vec_t        tbl [8];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] frame_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: decode to real numbers and apply a plain strict compare.
    function automatic real to_real(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 0)        m = 0.0;
        else if (e == 255) m = 1.0e300;
        else               m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -m : m;
    endfunction

    function automatic logic word_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic model(input bit find_min, input int idx_w,
                         output logic [31:0] v, output logic [31:0] idx,
                         output logic nan, output logic ovf);
        bit  have;
        real best;
        real r;
        int  bi;
        have = 0; best = 0.0; bi = 0; nan = 1'b0; v = QNAN;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (word_is_nan(frame_q[i])) begin
                nan = 1'b1;
            end else begin
                r = to_real(frame_q[i]);
                if (!have || (find_min ? (r < best) : (r > best))) begin
                    have = 1; best = r; bi = i; v = frame_q[i];
                end
            end
        end
        idx = 32'(bi % (1 << idx_w));
        ovf = (frame_q.size() > (1 << idx_w));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0: w = $urandom;
            1: case ($urandom_range(0, 9))
                   0: w = 32'h0000_0000;  1: w = 32'h8000_0000;
                   2: w = 32'h0000_0001;  3: w = 32'h8000_0001;
                   4: w = 32'h7F80_0000;  5: w = 32'hFF80_0000;
                   6: w = 32'h7FC0_0000;  7: w = 32'h3F80_0000;
                   8: w = 32'hBF80_0000;  default: w = 32'h7F80_0001;
               endcase
            default: w = {1'($urandom_range(0, 1)), 8'($urandom_range(125, 128)),
                          2'($urandom_range(0, 3)), 21'd0};
        endcase
        return w;
    endfunction

    // Presents frame_q with random idle gaps, then checks the result appears
    // exactly one cycle after the final handshake.
    task automatic send_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            chk("in_ready_accum", {31'd0, a_ready}, 32'd1);
            if (in_last) chk("valid_before_last", {31'd0, a_valid}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        chk("latency_valid", {29'd0, a_valid, b_valid, c_valid}, 32'd7);
    endtask

    task automatic check_outputs(input string tag,
        input logic [31:0] av, input logic [31:0] ai, input logic an, input logic ao,
        input logic [31:0] bv, input logic [31:0] bi, input logic bn, input logic bo,
        input logic [31:0] cv, input logic [31:0] ci, input logic cn, input logic co);
        chk({tag, "_max_value"}, a_value, av);
        chk({tag, "_max_index"}, 32'(a_index), ai);
        chk({tag, "_max_flags"}, {30'd0, a_nan, a_ovf}, {30'd0, an, ao});
        chk({tag, "_min_value"}, b_value, bv);
        chk({tag, "_min_index"}, 32'(b_index), bi);
        chk({tag, "_min_flags"}, {30'd0, b_nan, b_ovf}, {30'd0, bn, bo});
        chk({tag, "_nar_value"}, c_value, cv);
        chk({tag, "_nar_index"}, 32'(c_index), ci);
        chk({tag, "_nar_flags"}, {30'd0, c_nan, c_ovf}, {30'd0, cn, co});
    endtask

    // Holds the result for 'hold' cycles while throwing ignored beats at
    // the block, then accepts the result.
    task automatic release_result(input int hold);
        logic [31:0] snap_v;
        logic [7:0]  snap_i;
        snap_v = a_value;
        snap_i = a_index;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_ready", {29'd0, a_ready, b_ready, c_ready}, 32'd0);
            chk("hold_valid", {31'd0, a_valid}, 32'd1);
            chk("hold_value", a_value, snap_v);
            chk("hold_index", 32'(a_index), 32'(snap_i));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_accept_valid", {31'd0, a_valid}, 32'd0);
        chk("post_accept_ready", {31'd0, a_ready}, 32'd1);
    endtask

    task automatic load_table(input int t);
        frame_q = {};
        for (int k = 0; k < tbl[t].len; k++) frame_q.push_back(tbl[t].w[k]);
    endtask

    initial begin
        logic [31:0] mv, mi, nv, ni, xv, xi;
        logic        mn, mo, nn, no, xn, xo;

        tbl[0] = '{w: '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 0, 0, 0}, len: 3,
                   max_val: 32'h4000_0000, max_idx: 1, min_val: 32'h3F00_0000, min_idx: 2,
                   nan: 1'b0, n_idx: 1, n_ovf: 1'b0};
        tbl[1] = '{w: '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 0, 0, 0}, len: 3,
                   max_val: 32'h0000_0000, max_idx: 0, min_val: 32'h0000_0000, min_idx: 0,
                   nan: 1'b0, n_idx: 0, n_ovf: 1'b0};
        tbl[2] = '{w: '{32'h7FC0_0000, 32'hBF80_0000, 32'h7F80_0001, 32'hC000_0000, 0, 0}, len: 4,
                   max_val: 32'hBF80_0000, max_idx: 1, min_val: 32'hC000_0000, min_idx: 3,
                   nan: 1'b1, n_idx: 1, n_ovf: 1'b0};
        tbl[3] = '{w: '{32'h7FC0_0000, 32'hFFC0_0001, 0, 0, 0, 0}, len: 2,
                   max_val: QNAN, max_idx: 0, min_val: QNAN, min_idx: 0,
                   nan: 1'b1, n_idx: 0, n_ovf: 1'b0};
        tbl[4] = '{w: '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 0},
                   len: 5, max_val: 32'h40A0_0000, max_idx: 4, min_val: 32'h3F80_0000, min_idx: 0,
                   nan: 1'b0, n_idx: 0, n_ovf: 1'b1};
        tbl[5] = '{w: '{32'hC2C8_0000, 0, 0, 0, 0, 0}, len: 1,
                   max_val: 32'hC2C8_0000, max_idx: 0, min_val: 32'hC2C8_0000, min_idx: 0,
                   nan: 1'b0, n_idx: 0, n_ovf: 1'b0};
        tbl[6] = '{w: '{32'hFF80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 0, 0, 0}, len: 3,
                   max_val: 32'h7F80_0000, max_idx: 1, min_val: 32'hFF80_0000, min_idx: 0,
                   nan: 1'b0, n_idx: 1, n_ovf: 1'b0};
        tbl[7] = '{w: '{32'h8000_0001, 32'h0000_0000, 32'h8000_0000, 0, 0, 0}, len: 3,
                   max_val: 32'h8000_0001, max_idx: 0, min_val: 32'h8000_0001, min_idx: 0,
                   nan: 1'b0, n_idx: 0, n_ovf: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("reset_valid", {29'd0, a_valid, b_valid, c_valid}, 32'd0);
        chk("reset_ready", {29'd0, a_ready, b_ready, c_ready}, 32'd7);
        chk("reset_value", a_value, 32'd0);
        chk("reset_index", 32'(a_index), 32'd0);
        chk("reset_flags", {30'd0, a_nan, a_ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            load_table(t);
            send_frame();
            check_outputs($sformatf("tbl%0d", t),
                tbl[t].max_val, 32'(tbl[t].max_idx), tbl[t].nan, 1'b0,
                tbl[t].min_val, 32'(tbl[t].min_idx), tbl[t].nan, 1'b0,
                tbl[t].max_val, 32'(tbl[t].n_idx), tbl[t].nan, tbl[t].n_ovf);
            release_result((t == 1) ? 10 : $urandom_range(0, 3));
        end

        // Reset in the middle of a frame that has already seen a NaN.
        in_valid = 1'b1; in_last = 1'b0; in_data = 32'h7FC0_0000;
        @(negedge clk);
        in_data = 32'h7F7F_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midframe_rst_valid", {31'd0, a_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midframe_rst_valid2", {31'd0, a_valid}, 32'd0);
        load_table(0);
        send_frame();
        check_outputs("after_rst",
            32'h4000_0000, 32'd1, 1'b0, 1'b0, 32'h3F00_0000, 32'd2, 1'b0, 1'b0,
            32'h4000_0000, 32'd1, 1'b0, 1'b0);

        // Reset while a result is pending discards it.
        rst_n = 1'b0;
        @(negedge clk);
        chk("hold_rst_valid", {29'd0, a_valid, b_valid, c_valid}, 32'd0);
        chk("hold_rst_value", a_value, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hold_rst_ready", {31'd0, a_ready}, 32'd1);

        for (int f = 0; f < 60; f++) begin
            frame_q = {};
            for (int k = 0; k < $urandom_range(1, 12); k++) frame_q.push_back(rand_word());
            model(1'b0, 8, mv, mi, mn, mo);
            model(1'b1, 8, nv, ni, nn, no);
            model(1'b0, 2, xv, xi, xn, xo);
            send_frame();
            check_outputs($sformatf("rnd%0d", f), mv, mi, mn, mo, nv, ni, nn, no, xv, xi, xn, xo);
            release_result($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
